// File: rtl/mem_port_arbiter.sv
`timescale 1ns / 1ps
// mem_port_arbiter
//
// Shares one byte-addressed memory between the instruction-fetch port and
// the load/store port. Each access is a three-step sequence: grant (in IDLE
// or RESP), one ACCESS cycle on the memory bus, then a one-cycle response
// pulse to the owner. Data normally wins over fetch; after STARVE_LIMIT
// consecutive data grants with fetch waiting, fetch is forced through.
// Alignment is checked at grant; a faulting access never touches memory.
//
// Optional build macro: ARB_PERF_CNT_EN adds saturating performance counters.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   if_req, if_addr          fetch request / byte address
//   if_gnt                   fetch accepted this cycle (combinational)
//   if_rvalid/rdata/err      fetch response pulse, word, misaligned flag
//   d_req, d_we, d_size,
//   d_signed, d_addr,
//   d_wdata                  load/store request fields
//   d_gnt                    data accepted this cycle (combinational)
//   d_rvalid/rdata/err       data response pulse, load result, fault flag
//   mem_addr/read/write/
//   size/signed/wdata        memory controls, non-zero only during ACCESS
//   mem_rdata                memory combinational read data
//   cnt_conflict             (ARB_PERF_CNT_EN) cycles with both requests
//                            while a grant is possible
//   cnt_if_stall             (ARB_PERF_CNT_EN) cycles fetch waits
//   cnt_starve               (ARB_PERF_CNT_EN) forced fetch wins
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [1:0]        mem_size,
    output logic              mem_signed,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]       cnt_conflict,
    output logic [15:0]       cnt_if_stall,
    output logic [15:0]       cnt_starve
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;

    // Latched request; owner_if_q = 1 means the fetch port owns the access.
    logic              owner_if_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [DATA_W-1:0] rdata_q;

    logic              arb_en;
    logic              force_if;
    logic              d_fault;
    logic              if_fault;
    logic              in_access;
    logic              in_resp;

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    // Grants are only possible outside ACCESS.
    assign arb_en   = !in_access;
    assign force_if = if_req && (starve_cnt_q == STARVE_MAX);
    assign d_gnt    = arb_en && d_req && !force_if;
    assign if_gnt   = arb_en && if_req && !d_gnt;

    assign d_fault  = (d_size == 2'b11)
                   || ((d_size == 2'b00) && (d_addr[1:0] != 2'b00))
                   || ((d_size == 2'b01) && d_addr[0]);
    assign if_fault = (if_addr[1:0] != 2'b00);

    // Starvation counter: counts data wins over a waiting fetch.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = (if_gnt || d_gnt) ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = (if_gnt || d_gnt) ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            owner_if_q   <= 1'b0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            if (if_gnt || d_gnt) begin
                owner_if_q <= if_gnt;
                addr_q     <= if_gnt ? if_addr : d_addr;
                we_q       <= d_gnt && d_we;
                size_q     <= d_gnt ? d_size : 2'b00;
                signed_q   <= d_gnt && d_signed;
                wdata_q    <= d_gnt ? d_wdata : '0;
                err_q      <= if_gnt ? if_fault : d_fault;
            end
            // Stores and faulting accesses return zero.
            if (in_access) begin
                rdata_q <= mem_read ? mem_rdata : '0;
            end
        end
    end

    // Memory bus: everything is held at zero outside ACCESS, so an async
    // reset during a store drops mem_write immediately.
    assign mem_read   = in_access && !err_q && !we_q;
    assign mem_write  = in_access && !err_q && we_q;
    assign mem_addr   = in_access ? addr_q : '0;
    assign mem_size   = in_access ? size_q : 2'b00;
    assign mem_signed = in_access && signed_q;
    assign mem_wdata  = mem_write ? wdata_q : '0;

    assign if_rvalid  = in_resp && owner_if_q;
    assign d_rvalid   = in_resp && !owner_if_q;
    assign if_rdata   = if_rvalid ? rdata_q : '0;
    assign d_rdata    = d_rvalid ? rdata_q : '0;
    assign if_err     = if_rvalid && err_q;
    assign d_err      = d_rvalid && err_q;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] cnt_conflict_q;
    logic [15:0] cnt_if_stall_q;
    logic [15:0] cnt_starve_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_conflict_q <= '0;
            cnt_if_stall_q <= '0;
            cnt_starve_q   <= '0;
        end else begin
            if (arb_en && if_req && d_req && (cnt_conflict_q != 16'hFFFF)) begin
                cnt_conflict_q <= cnt_conflict_q + 16'd1;
            end
            if (if_req && !if_gnt && (cnt_if_stall_q != 16'hFFFF)) begin
                cnt_if_stall_q <= cnt_if_stall_q + 16'd1;
            end
            // Only a win that data would otherwise have taken counts.
            if (if_gnt && force_if && d_req && (cnt_starve_q != 16'hFFFF)) begin
                cnt_starve_q <= cnt_starve_q + 16'd1;
            end
        end
    end

    assign cnt_conflict = cnt_conflict_q;
    assign cnt_if_stall = cnt_if_stall_q;
    assign cnt_starve   = cnt_starve_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns / 1ps
module tb_mem_port_arbiter;

    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_signed, d_gnt, d_rvalid, d_err;
    logic [1:0]  d_size;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic [7:0]  mem_addr;
    logic        mem_read, mem_write, mem_signed;
    logic [1:0]  mem_size;
    logic [31:0] mem_wdata, mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_gnt     (if_gnt),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_size     (d_size),
        .d_signed   (d_signed),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_size   (mem_size),
        .mem_signed (mem_signed),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory behind the arbiter: combinational read with size/sign handling,
    // write mid-cycle while mem_write is high.
    logic [7:0] mem     [256];
    logic [7:0] img     [256];
    logic [7:0] ref_mem [256];
    logic       load_img = 1'b0;
    logic [7:0] rb0, rb1, rb2, rb3;

    always_comb begin
        rb0 = mem[mem_addr];
        rb1 = mem[8'(mem_addr + 8'd1)];
        rb2 = mem[8'(mem_addr + 8'd2)];
        rb3 = mem[8'(mem_addr + 8'd3)];
        case (mem_size)
            2'b00:   mem_rdata = {rb3, rb2, rb1, rb0};
            2'b01:   mem_rdata = {{16{mem_signed & rb1[7]}}, rb1, rb0};
            default: mem_rdata = {{24{mem_signed & rb0[7]}}, rb0};
        endcase
    end

    always @(negedge clk) begin
        if (load_img) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_size != 2'b10) mem[8'(mem_addr + 8'd1)] <= mem_wdata[15:8];
            if (mem_size == 2'b00) begin
                mem[8'(mem_addr + 8'd2)] <= mem_wdata[23:16];
                mem[8'(mem_addr + 8'd3)] <= mem_wdata[31:24];
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model helpers ----------------
    function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [1:0] sz,
                                             input logic sg);
        logic [31:0] w;
        w = {ref_mem[8'(a + 8'd3)], ref_mem[8'(a + 8'd2)], ref_mem[8'(a + 8'd1)], ref_mem[a]};
        if (sz == 2'b00) return w;
        if (sz == 2'b01) return sg ? 32'(signed'(w[15:0])) : {16'h0, w[15:0]};
        return sg ? 32'(signed'(w[7:0])) : {24'h0, w[7:0]};
    endfunction

    task automatic ref_store(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int nbytes;
        nbytes = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
        for (int i = 0; i < nbytes; i++) ref_mem[8'(a + 8'(i))] = wd[8*i +: 8];
    endtask

    function automatic logic data_fault(input logic [7:0] a, input logic [1:0] sz);
        return (sz == 2'b11) || (sz == 2'b00 && a[1:0] != 2'b00) || (sz == 2'b01 && a[0]);
    endfunction

    task automatic set_word(input logic [7:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            img[8'(a + 8'(i))]     = w[8*i +: 8];
            ref_mem[8'(a + 8'(i))] = w[8*i +: 8];
        end
    endtask

    task automatic push_image();
        load_img = 1'b1;
        @(negedge clk);
        #1 load_img = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        fetch;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    function automatic vec_t mk(input logic f, input logic we, input logic [1:0] sz,
                                input logic sg, input logic [7:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input logic er);
        vec_t v;
        v.fetch = f; v.we = we; v.size = sz; v.sgn = sg; v.addr = a;
        v.wdata = wd; v.exp_rdata = rd; v.exp_err = er;
        return v;
    endfunction

    task automatic do_txn(input vec_t v, input string tag);
        int   waited;
        logic exp_rd, exp_wr;
        waited = 0;
        @(posedge clk);
        #1;
        if (v.fetch) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = v.we; d_size = v.size; d_signed = v.sgn;
            d_addr = v.addr; d_wdata = v.wdata;
        end
        @(negedge clk);
        while (!(v.fetch ? if_gnt : d_gnt) && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_gnt_wait"}, 64'(waited), 64'(0));
        @(posedge clk);
        #1;
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        exp_rd = !v.exp_err && (v.fetch || !v.we);
        exp_wr = !v.exp_err && !v.fetch && v.we;
        check({tag, "_mem_ctl"}, 64'({mem_read, mem_write}), 64'({exp_rd, exp_wr}));
        if (exp_rd || exp_wr) check({tag, "_mem_addr"}, 64'(mem_addr), 64'(v.addr));
        @(negedge clk);
        check({tag, "_mem_idle"}, 64'({mem_read, mem_write}), 64'(0));
        check({tag, "_rvalid"}, 64'({if_rvalid, d_rvalid}), 64'({v.fetch, !v.fetch}));
        check({tag, "_resp"},
              v.fetch ? 64'({if_err, if_rdata}) : 64'({d_err, d_rdata}),
              64'({v.exp_err, v.exp_rdata}));
    endtask

    // ---------------- random-phase model state ----------------
    typedef struct {
        logic        valid;
        logic        fetch;
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } txn_t;

    vec_t vecs[15];
    logic exp_order [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic got_order [8];

    initial begin
        int   waited, ng, starve;
        logic rv, win_d, win_f;
        txn_t acc, rsp, nxt;

        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_signed = 0;
        d_addr = 0; d_wdata = 0;

        vecs[0]  = mk(1, 0, 2'b00, 0, 8'h00, 32'h0, 32'h00a00093, 0);
        vecs[1]  = mk(0, 1, 2'b00, 0, 8'h70, 32'h80000000, 32'h0, 0);
        vecs[2]  = mk(0, 0, 2'b10, 1, 8'h73, 32'h0, 32'hFFFFFF80, 0);
        vecs[3]  = mk(0, 0, 2'b10, 0, 8'h73, 32'h0, 32'h00000080, 0);
        vecs[4]  = mk(0, 0, 2'b01, 1, 8'h72, 32'h0, 32'hFFFF8000, 0);
        vecs[5]  = mk(0, 0, 2'b01, 0, 8'h72, 32'h0, 32'h00008000, 0);
        vecs[6]  = mk(0, 0, 2'b00, 0, 8'h70, 32'h0, 32'h80000000, 0);
        vecs[7]  = mk(0, 0, 2'b00, 0, 8'h02, 32'h0, 32'h0, 1);
        vecs[8]  = mk(0, 0, 2'b11, 0, 8'h40, 32'h0, 32'h0, 1);
        vecs[9]  = mk(1, 0, 2'b00, 0, 8'h05, 32'h0, 32'h0, 1);
        vecs[10] = mk(0, 0, 2'b01, 1, 8'h71, 32'h0, 32'h0, 1);
        vecs[11] = mk(0, 1, 2'b10, 0, 8'h74, 32'h123456A5, 32'h0, 0);
        vecs[12] = mk(0, 0, 2'b00, 0, 8'h74, 32'h0, 32'h000000A5, 0);
        vecs[13] = mk(0, 1, 2'b01, 0, 8'h78, 32'hCAFEBEEF, 32'h0, 0);
        vecs[14] = mk(0, 0, 2'b00, 0, 8'h78, 32'h0, 32'h0000BEEF, 0);

        for (int i = 0; i < 256; i++) begin img[i] = 8'h00; ref_mem[i] = 8'h00; end
        set_word(8'h00, 32'h00a00093);
        set_word(8'h04, 32'h12345678);
        set_word(8'h10, 32'h11223344);
        push_image();

        // Reset state, during and just after reset.
        check("rst_ctl", 64'({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err,
                              mem_read, mem_write, mem_signed, mem_size}), 64'(0));
        check("rst_data", {if_rdata, d_rdata}, 64'(0));
        check("rst_mem", 64'({mem_addr, mem_wdata}), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_idle", 64'({if_rvalid, d_rvalid, mem_read, mem_write}), 64'(0));

        for (int i = 0; i < 15; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // Contention: both held high, data wins STARVE_LIMIT times, then fetch.
        @(posedge clk);
        #1;
        if_req = 1; if_addr = 8'h00;
        d_req = 1; d_we = 0; d_size = 2'b00; d_signed = 0; d_addr = 8'h04;
        ng = 0;
        for (int c = 0; c < 40 && ng < 8; c++) begin
            @(negedge clk);
            if (if_gnt && d_gnt) check("cont_onehot", 64'({if_gnt, d_gnt}), 64'(1));
            if (if_gnt || d_gnt) begin
                got_order[ng] = d_gnt;
                ng++;
            end
        end
        check("cont_count", 64'(ng), 64'(8));
        for (int i = 0; i < 8; i++) begin
            if (i < ng) check($sformatf("cont_grant%0d_is_data", i),
                              64'(got_order[i]), 64'(exp_order[i]));
        end
        @(posedge clk);
        #1;
        if_req = 0; d_req = 0;
        repeat (3) @(posedge clk);

        // Back-to-back loads: second grant coincides with first response.
        #1;
        d_req = 1; d_we = 0; d_size = 2'b00; d_signed = 0; d_addr = 8'h00;
        waited = 0;
        @(negedge clk);
        while (!d_gnt && waited < 10) begin @(negedge clk); waited++; end
        check("b2b_gnt0_wait", 64'(waited), 64'(0));
        @(posedge clk);
        #1 d_addr = 8'h04;
        @(negedge clk);
        check("b2b_t1", 64'({d_gnt, d_rvalid, mem_read, mem_addr}), 64'({3'b001, 8'h00}));
        @(negedge clk);
        check("b2b_t2", 64'({d_gnt, d_rvalid, d_rdata}), 64'({2'b11, 32'h00a00093}));
        @(posedge clk);
        #1 d_req = 0;
        @(negedge clk);
        check("b2b_t3", 64'({d_gnt, d_rvalid, mem_read, mem_addr}), 64'({3'b001, 8'h04}));
        @(negedge clk);
        check("b2b_t4", 64'({d_gnt, d_rvalid, d_rdata}), 64'({2'b01, 32'h12345678}));

        // Reset in the ACCESS cycle of a store: the write must never land.
        @(posedge clk);
        #1;
        d_req = 1; d_we = 1; d_size = 2'b00; d_signed = 0; d_addr = 8'h10;
        d_wdata = 32'hDEADBEEF;
        waited = 0;
        @(negedge clk);
        while (!d_gnt && waited < 10) begin @(negedge clk); waited++; end
        check("rms_gnt_wait", 64'(waited), 64'(0));
        @(posedge clk);
        #1 d_req = 0;
        check("rms_write_before", 64'({mem_write, mem_addr}), 64'({1'b1, 8'h10}));
        rst = 1'b0;
        #1;
        check("rms_ctl", 64'({if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err,
                              mem_read, mem_write, mem_signed, mem_size}), 64'(0));
        check("rms_data", {if_rdata, d_rdata}, 64'(0));
        check("rms_mem", 64'({mem_addr, mem_wdata}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        rv = 1'b0;
        repeat (4) begin
            @(negedge clk);
            rv = rv | d_rvalid | if_rvalid;
        end
        check("rms_no_rvalid", 64'(rv), 64'(0));
        check("rms_mem_kept", 64'({mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}),
              64'(32'h11223344));
        do_txn(mk(1, 0, 2'b00, 0, 8'h04, 32'h0, 32'h12345678, 0), "post_rst");

        // Randomized traffic against a transaction-level model.
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            img[i] = 8'($urandom);
            ref_mem[i] = img[i];
        end
        push_image();
        rst = 1'b1;
        starve = 0;
        acc = '{valid: 0, fetch: 0, rd: 0, wr: 0, addr: 0, wdata: 0, rdata: 0, err: 0};
        rsp = acc;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            // A new access may start only when none is on the memory bus.
            win_d = !acc.valid && d_req && !(if_req && starve == LIMIT);
            win_f = !acc.valid && if_req && !win_d;
            check("rnd_gnt", 64'({if_gnt, d_gnt}), 64'({win_f, win_d}));
            check("rnd_mem_ctl", 64'({mem_read, mem_write}),
                  acc.valid ? 64'({acc.rd, acc.wr}) : 64'(0));
            if (acc.valid && (acc.rd || acc.wr))
                check("rnd_mem_addr", 64'(mem_addr), 64'(acc.addr));
            if (acc.valid && acc.wr) check("rnd_mem_wdata", 64'(mem_wdata), 64'(acc.wdata));
            check("rnd_rvalid", 64'({if_rvalid, d_rvalid}),
                  rsp.valid ? 64'({rsp.fetch, !rsp.fetch}) : 64'(0));
            if (rsp.valid)
                check("rnd_resp", rsp.fetch ? 64'({if_err, if_rdata}) : 64'({d_err, d_rdata}),
                      64'({rsp.err, rsp.rdata}));

            if (!if_req || win_f) starve = 0;
            else if (win_d && starve < LIMIT) starve++;

            nxt = '{valid: 0, fetch: 0, rd: 0, wr: 0, addr: 0, wdata: 0, rdata: 0, err: 0};
            if (win_f) begin
                nxt.valid = 1; nxt.fetch = 1; nxt.addr = if_addr;
                nxt.err = (if_addr[1:0] != 2'b00);
                nxt.rd = !nxt.err;
                nxt.rdata = nxt.rd ? ref_load(if_addr, 2'b00, 1'b0) : 32'h0;
            end else if (win_d) begin
                nxt.valid = 1; nxt.fetch = 0; nxt.addr = d_addr; nxt.wdata = d_wdata;
                nxt.err = data_fault(d_addr, d_size);
                nxt.rd = !nxt.err && !d_we;
                nxt.wr = !nxt.err && d_we;
                nxt.rdata = nxt.rd ? ref_load(d_addr, d_size, d_signed) : 32'h0;
                if (nxt.wr) ref_store(d_addr, d_size, d_wdata);
            end
            rsp = acc;
            acc = nxt;

            @(posedge clk);
            #1;
            if (!if_req || win_f) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = ($urandom_range(0, 4) == 0) ? 8'($urandom) : (8'($urandom) & 8'hFC);
            end
            if (!d_req || win_d) begin
                d_req    = ($urandom_range(0, 2) != 0);
                d_we     = 1'($urandom);
                d_size   = 2'($urandom_range(0, 3));
                d_signed = 1'($urandom);
                d_wdata  = $urandom;
                d_addr   = 8'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    if (d_size == 2'b00) d_addr = d_addr & 8'hFC;
                    if (d_size == 2'b01) d_addr = d_addr & 8'hFE;
                end
            end
        end
        if_req = 0; d_req = 0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
